// File: rtl/i2c_mt9v034_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_mt9v034_cfg_sequencer
//
// Purpose:
//   Walks the MT9V034 register-configuration LUT from entry 0 to lut_size-1
//   after power-up. Each entry becomes one I2C transaction handed to the
//   external byte-level I2C transaction engine. Entries below READ_NUM are
//   issued as reads and their returned data is compared with the LUT value.
//   All other entries are issued as writes. Completion or abort is reported
//   to the system init logic.
//
// Optional feature (compile-time macro):
//   I2C_RETRY_EN  - when defined, a NACKed entry is re-issued up to MAX_RETRY
//                   times before the sequence aborts. When undefined, the
//                   first NACK aborts and no retry counter exists.
//
// Parameters:
//   INIT_DELAY  clk cycles to wait after reset before the first transaction
//   GAP_CYCLES  idle clk cycles between consecutive transactions
//   READ_NUM    LUT indices 0..READ_NUM-1 are reads, the rest are writes
//   MAX_RETRY   re-issues allowed per entry after a NACK (I2C_RETRY_EN only)
//
// Ports:
//   clk_i          system clock, single clock domain
//   rst_n_i        asynchronous active-low reset
//   cfg_restart_i  1-cycle pulse, rerun the sequence (only when not busy)
//   lut_size_i     number of LUT entries to process
//   lut_data_i     {reg_addr[23:16], value[15:0]} of the entry at lut_index_o
//   lut_index_o    current LUT entry
//   i2c_req_o      transaction request level, held until i2c_done_i
//   i2c_rw_o       1 = read, 0 = write; stable while i2c_req_o is high
//   i2c_reg_o      register address; stable while i2c_req_o is high
//   i2c_wdata_o    write data; stable while i2c_req_o is high
//   i2c_done_i     1-cycle pulse, transaction finished
//   i2c_nack_i     qualified by i2c_done_i, slave did not acknowledge
//   i2c_rdata_i    read data, valid with i2c_done_i on reads
//   cfg_busy_o     sequence in progress
//   cfg_done_o     all entries completed, held until restart or reset
//   cfg_error_o    aborted on NACK, held until restart or reset
//   rd_mismatch_o  sticky, a read returned data different from the LUT value
// ---------------------------------------------------------------------------
module i2c_mt9v034_cfg_sequencer #(
  parameter int unsigned INIT_DELAY = 1_000_000,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  READ_NUM   = 8'd2,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cfg_restart_i,
  input  logic [7:0]  lut_size_i,
  input  logic [23:0] lut_data_i,
  output logic [7:0]  lut_index_o,
  output logic        i2c_req_o,
  output logic        i2c_rw_o,
  output logic [7:0]  i2c_reg_o,
  output logic [15:0] i2c_wdata_o,
  input  logic        i2c_done_i,
  input  logic        i2c_nack_i,
  input  logic [15:0] i2c_rdata_i,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_error_o,
  output logic        rd_mismatch_o
);

  // One shared down-timer serves both the power-up delay and the
  // inter-transaction gap, so it is sized for the longer of the two.
  localparam int unsigned CNT_MAX = (INIT_DELAY > GAP_CYCLES) ? INIT_DELAY : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  // Terminal counts; a zero-length delay degenerates to a single cycle.
  localparam logic [CNT_W-1:0] INIT_LAST = (INIT_DELAY == 0) ? '0 : CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  delayCnt_q, delayCnt_d;
  logic [7:0]        lutIndex_q, lutIndex_d;
  logic              req_q, req_d;
  logic              rw_q, rw_d;
  logic [7:0]        regAddr_q, regAddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              mismatch_q, mismatch_d;
  logic [7:0]        nextIndex;

`ifdef I2C_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retryCnt_q, retryCnt_d;
`endif

  assign nextIndex = lutIndex_q + 8'd1;

  // State register and all datapath registers. The reset clears the request
  // line asynchronously so an aborted transaction is withdrawn at once, and
  // the sequence starts again from the power-up delay.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_INIT;
      delayCnt_q <= '0;
      lutIndex_q <= '0;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      regAddr_q  <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mismatch_q <= 1'b0;
`ifdef I2C_RETRY_EN
      retryCnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      delayCnt_q <= delayCnt_d;
      lutIndex_q <= lutIndex_d;
      req_q      <= req_d;
      rw_q       <= rw_d;
      regAddr_q  <= regAddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mismatch_q <= mismatch_d;
`ifdef I2C_RETRY_EN
      retryCnt_q <= retryCnt_d;
`endif
    end
  end

  // Next-state and datapath logic. Everything holds by default. The
  // transaction fields are captured only in ISSUE, which keeps them frozen
  // for the whole WAIT even if the LUT output moves. i2c_done_i is looked at
  // only in WAIT and cfg_restart_i only in DONE/ERROR, so a stray done pulse
  // is harmless and done always beats a simultaneous restart.
  always_comb begin
    state_d    = state_q;
    delayCnt_d = delayCnt_q;
    lutIndex_d = lutIndex_q;
    req_d      = req_q;
    rw_d       = rw_q;
    regAddr_d  = regAddr_q;
    wdata_d    = wdata_q;
    mismatch_d = mismatch_q;
`ifdef I2C_RETRY_EN
    retryCnt_d = retryCnt_q;
`endif

    unique case (state_q)
      ST_INIT: begin
        if (delayCnt_q == INIT_LAST) begin
          delayCnt_d = '0;
          state_d    = (lut_size_i == 8'd0) ? ST_DONE : ST_ISSUE;
        end else begin
          delayCnt_d = delayCnt_q + 1'b1;
        end
      end

      ST_ISSUE: begin
        regAddr_d = lut_data_i[23:16];
        wdata_d   = lut_data_i[15:0];
        rw_d      = (lutIndex_q < READ_NUM);
        req_d     = 1'b1;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        if (i2c_done_i) begin
          req_d = 1'b0;
          if (!i2c_nack_i) begin
            if (rw_q && (i2c_rdata_i != lut_data_i[15:0])) begin
              mismatch_d = 1'b1;
            end
            lutIndex_d = nextIndex;
`ifdef I2C_RETRY_EN
            retryCnt_d = '0;
`endif
            state_d    = (nextIndex == lut_size_i) ? ST_DONE : ST_GAP;
          end else begin
`ifdef I2C_RETRY_EN
            if (retryCnt_q < RETRY_W'(MAX_RETRY)) begin
              retryCnt_d = retryCnt_q + 1'b1;
              state_d    = ST_GAP;
            end else begin
              state_d    = ST_ERROR;
            end
`else
            state_d = ST_ERROR;
`endif
          end
        end
      end

      ST_GAP: begin
        if (delayCnt_q == GAP_LAST) begin
          delayCnt_d = '0;
          state_d    = (lutIndex_q == lut_size_i) ? ST_DONE : ST_ISSUE;
        end else begin
          delayCnt_d = delayCnt_q + 1'b1;
        end
      end

      ST_DONE, ST_ERROR: begin
        if (cfg_restart_i) begin
          lutIndex_d = '0;
          delayCnt_d = '0;
          mismatch_d = 1'b0;
`ifdef I2C_RETRY_EN
          retryCnt_d = '0;
`endif
          state_d    = ST_GAP;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Status flags are registered from the next state so that all outputs read
  // zero while reset is held and change in step with the state register.
  always_comb begin
    busy_d  = (state_d == ST_INIT) || (state_d == ST_ISSUE) ||
              (state_d == ST_WAIT) || (state_d == ST_GAP);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  assign lut_index_o   = lutIndex_q;
  assign i2c_req_o     = req_q;
  assign i2c_rw_o      = rw_q;
  assign i2c_reg_o     = regAddr_q;
  assign i2c_wdata_o   = wdata_q;
  assign cfg_busy_o    = busy_q;
  assign cfg_done_o    = done_q;
  assign cfg_error_o   = error_q;
  assign rd_mismatch_o = mismatch_q;

endmodule

// File: tb/tb_i2c_mt9v034_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_mt9v034_cfg_sequencer
//
// Purpose:
//   Self-checking bench for i2c_mt9v034_cfg_sequencer. A behavioural model
//   turns the LUT contents and a per-entry NACK/corruption plan into the list
//   of I2C requests the sequencer should issue and the final flag values.
//   A monitor pops that list whenever a request appears. A small engine
//   model answers requests with randomized latency. Honours I2C_RETRY_EN.
// ---------------------------------------------------------------------------
module tb_i2c_mt9v034_cfg_sequencer;

  localparam int          INIT_DELAY = 40;
  localparam int          GAP_CYCLES = 16;
  localparam logic [7:0]  READ_NUM   = 8'd2;
  localparam int          MAX_RETRY  = 3;

  logic        clk;
  logic        rst_n;
  logic        cfg_restart;
  logic [7:0]  lut_size;
  logic [23:0] lut_data;
  logic [7:0]  lut_index;
  logic        i2c_req;
  logic        i2c_rw;
  logic [7:0]  i2c_reg;
  logic [15:0] i2c_wdata;
  logic        i2c_done;
  logic        i2c_nack;
  logic [15:0] i2c_rdata;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_error;
  logic        rd_mismatch;

  typedef struct {
    logic        rw;
    logic [7:0]  regAddr;
    logic [15:0] data;
    logic [7:0]  idx;
  } expReq_t;

  logic [23:0] lut [256];
  logic        overrideEn;
  logic [23:0] overrideVal;
  int          nackCount [256];
  bit          corrupt [256];
  int          attempts [256];
  int          strayIdx;
  int          slowIdx;
  expReq_t     expQ [$];
  bit          expErr;
  bit          expMism;
  int          expIdx;
  int          total;
  int          bad;

  i2c_mt9v034_cfg_sequencer #(
    .INIT_DELAY (INIT_DELAY),
    .GAP_CYCLES (GAP_CYCLES),
    .READ_NUM   (READ_NUM),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cfg_restart_i (cfg_restart),
    .lut_size_i    (lut_size),
    .lut_data_i    (lut_data),
    .lut_index_o   (lut_index),
    .i2c_req_o     (i2c_req),
    .i2c_rw_o      (i2c_rw),
    .i2c_reg_o     (i2c_reg),
    .i2c_wdata_o   (i2c_wdata),
    .i2c_done_i    (i2c_done),
    .i2c_nack_i    (i2c_nack),
    .i2c_rdata_i   (i2c_rdata),
    .cfg_busy_o    (cfg_busy),
    .cfg_done_o    (cfg_done),
    .cfg_error_o   (cfg_error),
    .rd_mismatch_o (rd_mismatch)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The LUT answers combinationally; the override lets a test disturb it.
  assign lut_data = overrideEn ? overrideVal : lut[lut_index];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // Random LUT with the known MT9V034 entries the scenarios refer to.
  task automatic fillLut();
    for (int i = 0; i < 256; i++) lut[i] = 24'($urandom());
    lut[1][15:0] = 16'h1313;
    lut[2]       = 24'h0C0001;
    lut[21]      = 24'h0D0330;
  endtask

  task automatic clearPlan();
    for (int i = 0; i < 256; i++) begin
      nackCount[i] = 0;
      corrupt[i]   = 1'b0;
      attempts[i]  = 0;
    end
    strayIdx = -1;
    slowIdx  = -1;
  endtask

  // Reference model: walk the entries, emit one expected request per attempt,
  // stop on the entry whose NACKs exceed what the build tolerates.
  task automatic applyStimulus(input int size);
    int tries;
    expReq_t e;
    lut_size = 8'(size);
    expQ.delete();
    expErr  = 1'b0;
    expMism = 1'b0;
    expIdx  = size;
    for (int i = 0; i < size; i++) begin
`ifdef I2C_RETRY_EN
      if (nackCount[i] > MAX_RETRY) begin
        tries  = MAX_RETRY + 1;
        expErr = 1'b1;
      end else begin
        tries = nackCount[i] + 1;
      end
`else
      tries = 1;
      if (nackCount[i] > 0) expErr = 1'b1;
`endif
      e.rw      = (i < int'(READ_NUM));
      e.regAddr = lut[i][23:16];
      e.data    = lut[i][15:0];
      e.idx     = 8'(i);
      for (int t = 0; t < tries; t++) expQ.push_back(e);
      if (expErr) begin
        expIdx = i;
        break;
      end
      if (e.rw && corrupt[i]) expMism = 1'b1;
    end
  endtask

  task automatic waitReq(input int idx);
    int n = 0;
    while (!(i2c_req && lut_index == 8'(idx)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) failNow("wait_req_index");
  endtask

  task automatic measureToReq(input int start, output int n);
    n = start;
    while (!i2c_req && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitFinal();
    int n = 0;
    while (!(cfg_done || cfg_error) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) failNow("final_timeout");
  endtask

  task automatic checkFinal(input string tag);
    checkOutput({tag, "_done"},     cfg_done,    !expErr);
    checkOutput({tag, "_error"},    cfg_error,   expErr);
    checkOutput({tag, "_mismatch"}, rd_mismatch, expMism);
    checkOutput({tag, "_index"},    lut_index,   expIdx);
    checkOutput({tag, "_busy"},     cfg_busy,    0);
    checkOutput({tag, "_req"},      i2c_req,     0);
    checkOutput({tag, "_pending"},  expQ.size(), 0);
  endtask

  task automatic restartPulse(input string tag);
    int n;
    @(negedge clk);
    cfg_restart = 1'b1;
    @(negedge clk);
    cfg_restart = 1'b0;
    checkOutput({tag, "_clr_done"},  cfg_done,    0);
    checkOutput({tag, "_clr_error"}, cfg_error,   0);
    checkOutput({tag, "_clr_mism"},  rd_mismatch, 0);
    checkOutput({tag, "_clr_index"}, lut_index,   0);
    checkOutput({tag, "_busy"},      cfg_busy,    1);
    measureToReq(1, n);
    checkOutput({tag, "_first_req_latency"}, n, GAP_CYCLES + 2);
  endtask

  // Engine model: answers each request after a random latency, NACKing the
  // first nackCount attempts of an entry and optionally corrupting reads.
  initial begin
    int idx;
    int lat;
    i2c_done  = 1'b0;
    i2c_nack  = 1'b0;
    i2c_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && i2c_req) begin
        idx = int'(lut_index);
        lat = (idx == slowIdx) ? 6 : int'($urandom_range(1, 4));
        repeat (lat) @(negedge clk);
        if (rst_n && i2c_req) begin
          i2c_nack  = (attempts[idx] < nackCount[idx]);
          i2c_rdata = corrupt[idx] ? (lut[idx][15:0] ^ 16'h0037) : lut[idx][15:0];
          attempts[idx]++;
          i2c_done = 1'b1;
          @(negedge clk);
          i2c_done = 1'b0;
          i2c_nack = 1'b0;
          if (idx == strayIdx) begin
            repeat (3) @(negedge clk);
            i2c_done  = 1'b1;
            i2c_nack  = 1'b1;
            i2c_rdata = 16'hDEAD;
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            checkOutput("stray_done_index", lut_index, idx + 1);
            checkOutput("stray_done_busy",  cfg_busy,  1);
          end
        end
      end
    end
  end

  // Monitor: every new request pops the next expected transaction; the
  // fields must match it for as long as the request is held.
  initial begin
    expReq_t cur;
    bit      prevReq = 1'b0;
    bit      haveCur = 1'b0;
    int      lowCount = 0;
    forever begin
      @(negedge clk);
      if (i2c_req && !prevReq) begin
        checkOutput("gap_before_req", lowCount >= GAP_CYCLES, 1);
        if (expQ.size() == 0) begin
          failNow("unexpected_req");
          haveCur = 1'b0;
        end else begin
          cur     = expQ.pop_front();
          haveCur = 1'b1;
        end
      end
      if (i2c_req && haveCur) begin
        checkOutput("req_rw",    i2c_rw,    cur.rw);
        checkOutput("req_reg",   i2c_reg,   cur.regAddr);
        checkOutput("req_wdata", i2c_wdata, cur.data);
        checkOutput("req_index", lut_index, cur.idx);
      end
      lowCount = i2c_req ? 0 : lowCount + 1;
      prevReq  = i2c_req;
    end
  end

  // Scenario sequence.
  initial begin
    int n;
    int size;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    cfg_restart = 1'b0;
    overrideEn  = 1'b0;
    overrideVal = '0;
    lut_size    = 8'd24;
    fillLut();
    clearPlan();
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_req",      i2c_req,     0);
    checkOutput("rst_busy",     cfg_busy,    0);
    checkOutput("rst_done",     cfg_done,    0);
    checkOutput("rst_error",    cfg_error,   0);
    checkOutput("rst_mismatch", rd_mismatch, 0);
    checkOutput("rst_index",    lut_index,   0);
    checkOutput("rst_fields",   {i2c_rw, i2c_reg, i2c_wdata}, 0);

    $display("[TB] run 1: clean 24-entry sequence with disturbances");
    strayIdx = 3;
    slowIdx  = 5;
    applyStimulus(24);
    rst_n = 1'b1;
    measureToReq(0, n);
    checkOutput("init_latency", n, INIT_DELAY + 1);
    waitReq(5);
    overrideEn  = 1'b1;
    overrideVal = ~lut[5];
    repeat (2) @(negedge clk);
    checkOutput("frozen_reg",   i2c_reg,   lut[5][23:16]);
    checkOutput("frozen_wdata", i2c_wdata, lut[5][15:0]);
    n = 0;
    while (i2c_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    overrideEn = 1'b0;
    waitReq(8);
    cfg_restart = 1'b1;
    @(negedge clk);
    cfg_restart = 1'b0;
    checkOutput("busy_restart_busy",  cfg_busy,  1);
    checkOutput("busy_restart_index", lut_index, 8);
    waitFinal();
    checkFinal("run1");

    $display("[TB] run 2: corrupted read on index 1, restart from DONE");
    clearPlan();
    fillLut();
    corrupt[1] = 1'b1;
    corrupt[0] = 1'($urandom_range(0, 1));
    applyStimulus(24);
    restartPulse("run2");
    waitFinal();
    checkFinal("run2");

    $display("[TB] run 3: two NACKs on index 21");
    clearPlan();
    fillLut();
    nackCount[21] = 2;
    applyStimulus(24);
    restartPulse("run3");
    waitFinal();
    checkFinal("run3");

    $display("[TB] run 4: persistent NACK on index 21");
    clearPlan();
    fillLut();
    nackCount[21] = 4;
    corrupt[0]    = 1'($urandom_range(0, 1));
    applyStimulus(24);
    restartPulse("run4");
    waitFinal();
    checkFinal("run4");

    $display("[TB] run 5: reset during WAIT at index 10");
    clearPlan();
    fillLut();
    applyStimulus(int'($urandom_range(12, 30)));
    restartPulse("run5");
    waitReq(10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req",   i2c_req,   0);
    checkOutput("async_rst_busy",  cfg_busy,  0);
    checkOutput("async_rst_index", lut_index, 0);
    repeat (3) @(negedge clk);
    clearPlan();
    fillLut();
    size = int'($urandom_range(3, 24));
    nackCount[2]        = 3;
    nackCount[size - 1] = 1;
    corrupt[0]          = 1'($urandom_range(0, 1));
    applyStimulus(size);
    rst_n = 1'b1;
    measureToReq(0, n);
    checkOutput("reinit_latency", n, INIT_DELAY + 1);
    checkOutput("reinit_index",   lut_index, 0);
    waitFinal();
    checkFinal("run5");

    $display("[TB] run 6: empty LUT");
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    clearPlan();
    applyStimulus(0);
    rst_n = 1'b1;
    repeat (INIT_DELAY - 5) @(negedge clk);
    checkOutput("empty_in_init_busy", cfg_busy, 1);
    checkOutput("empty_in_init_done", cfg_done, 0);
    repeat (10) @(negedge clk);
    checkFinal("run6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
